tc_stack: RTL
=============

Name: tc_stack

Overview:
- LIFO buffer that sits directly downstream of a register stage. It captures the register's output word on `save` (push) and returns the most recently saved word on `load` (pop).
- Its output port follows the same load-gated convention as the register block:
  - a word is presented only in the cycle after `load` is accepted;
  - otherwise the output is driven to zero.
- Single clock domain. Implements stack/return-address storage for the generated CPU netlists.

Parameters:
- UUID, 0, instance identifier passed through by the netlist generator; no functional effect.
- NAME, "", instance name; no functional effect.
- BIT_WIDTH, 8, width of each stored word and of `in`/`out`.
- DEPTH, 16, number of entries. Must be a power of two and ≥ 2.
- CNT_W, $clog2(DEPTH+1), width of `count` (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-low. Sampled on the rising edge of `clk`; when low, state is reset.
- load  input  1  pop request.
- save  input  1  push request.
- in  input  BIT_WIDTH  word to push.
- out  output  BIT_WIDTH  popped word, registered.
- empty  output  1  count == 0, registered.
- full  output  1  count == DEPTH, registered.
- count  output  CNT_W  number of valid entries, registered.
- overflow  output  1  sticky flag: push was refused because the stack was full.
- underflow  output  1  sticky flag: pop was refused because the stack was empty.

Behaviour:
- Reset (rst == 0 at posedge):
  - out = 0, count = 0, empty = 1, full = 0, overflow = 0, underflow = 0.
  - Storage array contents are not cleared and are don't-care.
  - Reset overrides `load` and `save` in the same cycle.
- Storage: array of DEPTH words plus a stack pointer sp in 0..DEPTH, where sp = count. The top of stack is entry sp-1.
- Latency: a pop issued at edge N drives `out` from edge N until edge N+1. This is one-cycle registered output, with no combinational path from inputs to `out`.
- `out` default: out <= 0 on every edge where no word is delivered (the load-gated convention).
- Per-edge decision, rst == 1, evaluated from the pre-edge state:
  - load=0, save=0: out <= 0; no state change.
  - save=1, load=0, not full: mem[sp] <= in; sp <= sp+1; out <= 0.
  - save=1, load=0, full: push dropped; overflow <= 1; sp unchanged; out <= 0.
  - load=1, save=0, not empty: out <= mem[sp-1]; sp <= sp-1.
  - load=1, save=0, empty: out <= 0; underflow <= 1; sp unchanged.
  - load=1, save=1, not empty (includes full): out <= mem[sp-1]; mem[sp-1] <= in; sp unchanged. This is a swap of the top entry; no flag changes.
  - load=1, save=1, empty: out <= in (bypass); sp stays 0; no flag changes.
- Flags: overflow and underflow are sticky and are cleared only by reset.
- Status outputs: empty, full and count update on the same edge as sp. They reflect the post-edge occupancy and never glitch between edges.
- Pointer bounds: sp never wraps. There is no modular addressing, and entries beyond sp are never read.
- Reset mid-operation: any pending push or pop in the reset cycle is discarded. The first push after reset lands at entry 0.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, release -> out=0, count=0, empty=1, full=0, overflow=0, underflow=0.
- Push/pop order (BIT_WIDTH=8, DEPTH=4):
  - Push 0x11, 0x22, 0x33 on consecutive cycles -> count=3.
  - Then 3 pops -> out=0x33, 0x22, 0x11 on successive cycles.
  - The cycle after the last pop -> out=0, empty=1.
- Full and overflow:
  - Push 0xA0..0xA3 -> full=1, count=4.
  - Push 0xFF -> overflow=1, count=4.
  - Pop -> out=0xA3 (0xFF was not stored).
  - overflow stays 1 until reset.
- Underflow: on an empty stack, pop -> out=0, underflow=1, count=0. A subsequent push of 0x5A succeeds -> count=1, underflow still 1.
- Simultaneous load and save:
  - Empty stack, load=save=1 with in=0x77 -> out=0x77, count=0.
  - With stack [0x10, 0x20], load=save=1 with in=0x99 -> out=0x20, count=2.
  - Next pop -> out=0x99.
- Reset mid-stream:
  - Push 3 words, then assert rst=0 in the same cycle as a push of 0x44 -> count=0, out=0.
  - After release, push 0x01 and pop -> out=0x01.

Source files
------------

// File: rtl/tc_stack.sv
// tc_stack: load-gated LIFO; save pushes in, load pops to out (zero otherwise); empty/full/count status; sticky overflow/underflow; rst is active-low sync
module tc_stack #(
    parameter int UUID = 0,
    parameter NAME = "",
    parameter int BIT_WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 save,
    input  logic [BIT_WIDTH-1:0] in,
    output logic [BIT_WIDTH-1:0] out,
    output logic                 empty,
    output logic                 full,
    output logic [CNT_W-1:0]     count,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int AW = $clog2(DEPTH);
    logic [BIT_WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] sp, sp_n;
    logic [AW-1:0] top_a, wr_a;
    logic is_empty, is_full, we;
    assign is_empty = sp == '0;
    assign is_full = sp == CNT_W'(DEPTH);
    assign top_a = AW'(sp - 1'b1);
    assign wr_a = load ? top_a : AW'(sp);
    assign we = rst && save && (load ? !is_empty : !is_full);
    assign count = sp;
    always_comb begin
        sp_n = (load && !save && !is_empty) ? sp - 1'b1 :
               (save && !load && !is_full) ? sp + 1'b1 : sp;
    end
    always_ff @(posedge clk) begin
        if (we) mem[wr_a] <= in;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            out <= '0;
            sp <= '0;
            empty <= 1'b1;
            full <= 1'b0;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else begin
            out <= !load ? '0 : !is_empty ? mem[top_a] : save ? in : '0;
            sp <= sp_n;
            empty <= sp_n == '0;
            full <= sp_n == CNT_W'(DEPTH);
            overflow <= overflow | (save && !load && is_full);
            underflow <= underflow | (load && !save && is_empty);
        end
    end
endmodule
